// File: rtl/cnn_state_update_pkg.sv
// Shared constants, FSM encodings and the signed saturation helper for the
// CNN cell state integrator.
package cnn_state_update_pkg;

  localparam int WIDTH    = 9;
  localparam int DT_SHIFT = 2;
  localparam int ITER_W   = 8;
  localparam int WIDE     = WIDTH + 2;
  localparam int LIM      = (1 << (WIDTH - 2)) - 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic signed [WIDE-1:0] LIM_POS = WIDE'(LIM);
  localparam logic signed [WIDE-1:0] LIM_NEG = -LIM_POS;

  // Saturate a widened intermediate back to +-LIM at WIDTH bits.
  function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [WIDE-1:0] v);
    if (v > LIM_POS)
      return LIM_POS[WIDTH-1:0];
    else if (v < LIM_NEG)
      return LIM_NEG[WIDTH-1:0];
    else
      return v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/cnn_step_alu.sv
// Combinational Euler step: dx = clamp((-x + fb + ctrl + bias) >>> DT_SHIFT)
// and the saturated next state.
module cnn_step_alu
  import cnn_state_update_pkg::*;
(
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] fb_sum,
  input  logic signed [WIDTH-1:0] ctrl_sum,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] dx,
  output logic signed [WIDTH-1:0] x_next
);

  logic signed [WIDE-1:0] x_w;
  logic signed [WIDE-1:0] fb_w;
  logic signed [WIDE-1:0] ctrl_w;
  logic signed [WIDE-1:0] bias_w;
  logic signed [WIDE-1:0] sum;
  logic signed [WIDE-1:0] dx_w;
  logic signed [WIDE-1:0] next_w;

  assign x_w    = {{2{x[WIDTH-1]}}, x};
  assign fb_w   = {{2{fb_sum[WIDTH-1]}}, fb_sum};
  assign ctrl_w = {{2{ctrl_sum[WIDTH-1]}}, ctrl_sum};
  assign bias_w = {{2{bias[WIDTH-1]}}, bias};

  // Two guard bits cover three full-range operands plus -x without wrap.
  assign sum    = fb_w + ctrl_w + bias_w - x_w;
  assign dx_w   = sum >>> DT_SHIFT;
  assign dx     = sat_clamp(dx_w);
  assign next_w = x_w + {{2{dx[WIDTH-1]}}, dx};
  assign x_next = sat_clamp(next_w);

endmodule

// File: rtl/cnn_state_update.sv
// CNN cell state integrator: holds X, runs Euler steps on handshaked
// operands until the step limit or convergence, presents (dX, X) downstream.
module cnn_state_update
  import cnn_state_update_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  x_init,
  input  logic [ITER_W-1:0]        max_iter,
  input  logic signed [WIDTH-1:0]  fb_sum,
  input  logic signed [WIDTH-1:0]  ctrl_sum,
  input  logic signed [WIDTH-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [WIDTH-1:0]  dX_out,
  output logic signed [WIDTH-1:0]  Initial_X_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic [ITER_W-1:0]        iter_count
);

  state_t                  state_reg;
  logic signed [WIDTH-1:0] x_reg;
  logic signed [WIDTH-1:0] dx_out_reg;
  logic signed [WIDTH-1:0] init_x_reg;
  logic                    out_valid_reg;
  logic                    converged_reg;
  logic [ITER_W-1:0]       iter_reg;
  logic [ITER_W-1:0]       max_iter_reg;

  logic signed [WIDTH-1:0] dx;
  logic signed [WIDTH-1:0] x_next;
  logic [ITER_W-1:0]       iter_inc;
  logic                    fire;

  cnn_step_alu u_alu (
    .x        (x_reg),
    .fb_sum   (fb_sum),
    .ctrl_sum (ctrl_sum),
    .bias     (bias),
    .dx       (dx),
    .x_next   (x_next)
  );

  assign fire     = (state_reg == ST_RUN) && in_valid;
  assign iter_inc = iter_reg + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      dx_out_reg    <= '0;
      init_x_reg    <= '0;
      out_valid_reg <= 1'b0;
      converged_reg <= 1'b0;
      iter_reg      <= '0;
      max_iter_reg  <= '0;
    end else begin
      out_valid_reg <= fire;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            x_reg         <= sat_clamp({{2{x_init[WIDTH-1]}}, x_init});
            iter_reg      <= '0;
            converged_reg <= 1'b0;
            max_iter_reg  <= max_iter;
            state_reg     <= (max_iter == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            dx_out_reg <= dx;
            init_x_reg <= x_reg;
            x_reg      <= x_next;
            iter_reg   <= iter_inc;
            // Convergence takes priority so the flag is set even on the last allowed step.
            if (dx == '0) begin
              converged_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end else if (iter_inc == max_iter_reg) begin
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_reg == ST_RUN);
  assign busy          = (state_reg == ST_RUN);
  assign done          = (state_reg == ST_DONE);
  assign dX_out        = dx_out_reg;
  assign Initial_X_out = init_x_reg;
  assign out_valid     = out_valid_reg;
  assign converged     = converged_reg;
  assign iter_count    = iter_reg;

endmodule

// File: tb/tb_cnn_state_update.sv
// Self-checking bench for cnn_state_update: vector table of whole runs with a
// step scoreboard, plus hand-written reset, gap and zero-limit sequences.
module tb_cnn_state_update;
  import cnn_state_update_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic signed [WIDTH-1:0] x_init;
  logic [ITER_W-1:0]       max_iter;
  logic signed [WIDTH-1:0] fb_sum;
  logic signed [WIDTH-1:0] ctrl_sum;
  logic signed [WIDTH-1:0] bias;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] dX_out;
  logic signed [WIDTH-1:0] Initial_X_out;
  logic                    out_valid;
  logic                    busy;
  logic                    done;
  logic                    converged;
  logic [ITER_W-1:0]       iter_count;

  cnn_state_update dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .x_init        (x_init),
    .max_iter      (max_iter),
    .fb_sum        (fb_sum),
    .ctrl_sum      (ctrl_sum),
    .bias          (bias),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dX_out        (dX_out),
    .Initial_X_out (Initial_X_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .iter_count    (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int m; int fb; int ctrl; int bias;
    int first_dx; int first_init; int iters; int conv; int gaps;
  } vec_t;

  typedef struct { int dx; int init; int cyc; } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;
  int   cyc_now = 0;
  int   model_x;
  int   ov_count;
  int   first_dx;
  int   first_init;
  bit   first_seen;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  // Floor division by 2^DT_SHIFT = 4, rounding toward minus infinity.
  function automatic int floor4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  task automatic push_step();
    int   s;
    int   d;
    exp_t e;
    s = -model_x + int'(fb_sum) + int'(ctrl_sum) + int'(bias);
    d = clampi(floor4(s));
    e.dx   = d;
    e.init = model_x;
    e.cyc  = cyc_now;
    sb.push_back(e);
    model_x = clampi(model_x + d);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      ov_count++;
      $display("step dx=%0d init=%0d iter=%0d", $signed(dX_out), $signed(Initial_X_out), iter_count);
      if (!first_seen) begin
        first_seen = 1'b1;
        first_dx   = int'($signed(dX_out));
        first_init = int'($signed(Initial_X_out));
      end
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("step_dx", int'($signed(dX_out)), e.dx);
        check("step_init", int'($signed(Initial_X_out)), e.init);
        check("step_latency", cyc_now, e.cyc + 1);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit phase;
    @(negedge clk);
    x_init   = WIDTH'(v.x);
    max_iter = ITER_W'(v.m);
    fb_sum   = WIDTH'(v.fb);
    ctrl_sum = WIDTH'(v.ctrl);
    bias     = WIDTH'(v.bias);
    start    = 1'b1;
    in_valid = 1'b0;
    model_x    = clampi(v.x);
    first_seen = 1'b0;
    ov_count   = 0;
    @(negedge clk);
    start = 1'b0;
    phase = 1'b1;
    cyc   = 0;
    while (!done && cyc < 300) begin
      if (v.gaps != 0) begin
        // Idle cycles carry a start pulse with a different x_init; RUN must ignore it.
        in_valid = phase;
        start    = !phase;
        x_init   = WIDTH'(77);
        phase    = !phase;
      end else begin
        in_valid = 1'b1;
      end
      if (in_valid && in_ready) push_step();
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("done_seen", int'(done), 1);
    check("done_out_valid", int'(out_valid), 1);
    check("done_iter_count", int'(iter_count), v.iters);
    check("done_converged", int'(converged), v.conv);
    @(negedge clk);
    check("after_done", int'(done), 0);
    check("after_busy", int'(busy), 0);
    check("conv_hold", int'(converged), v.conv);
    check("sb_empty", sb.size(), 0);
    check("first_dx", first_dx, v.first_dx);
    check("first_init", first_init, v.first_init);
    check("pulse_count", ov_count, v.iters);
    $display("run %0d x_init=%0d max_iter=%0d iters=%0d conv=%0d", idx, v.x, v.m, iter_count, converged);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dx"}, int'($signed(dX_out)), 0);
    check({tag, "_init"}, int'($signed(Initial_X_out)), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_converged"}, int'(converged), 0);
    check({tag, "_iter"}, int'(iter_count), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  initial begin
    // x, max_iter, fb, ctrl, bias, first dx, first init, iterations, converged, gaps
    vecs[0] = '{0,    1,  40,   0,    0,    10,   0,    1, 0, 0};
    vecs[1] = '{20,   5,  20,   0,    0,    0,    20,   1, 1, 0};
    vecs[2] = '{100,  2,  255,  255,  255,  127,  100,  2, 0, 0};
    vecs[3] = '{-256, 1,  0,    0,    0,    31,   -127, 1, 0, 0};
    vecs[4] = '{0,    20, 8,    0,    0,    2,    0,    5, 1, 0};
    vecs[5] = '{0,    20, -8,   0,    0,    -2,   0,    7, 1, 0};
    vecs[6] = '{50,   3,  0,    0,    0,    -13,  50,   3, 0, 0};
    vecs[7] = '{-127, 2,  -255, -255, -255, -127, -127, 2, 0, 0};
    vecs[8] = '{0,    3,  -5,   0,    0,    -2,   0,    3, 0, 1};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    x_init = '0; max_iter = '0; fb_sum = '0; ctrl_sum = '0; bias = '0;
    ov_count = 0; first_seen = 1'b0; model_x = 0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;

    // Reset in the middle of a run after two steps.
    @(negedge clk);
    x_init = '0; max_iter = ITER_W'(10); fb_sum = WIDTH'(40);
    start = 1'b1; model_x = 0;
    @(negedge clk);
    start = 1'b0;
    check("run_busy", int'(busy), 1);
    in_valid = 1'b1; push_step();
    @(negedge clk);
    push_step();
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_iter", int'(iter_count), 2);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    check("sb_after_reset", sb.size(), 0);
    @(negedge clk);
    check_all_zero("post_reset");
    $display("reset sequence complete");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Zero step limit: done one cycle after start, no step, never busy.
    @(negedge clk);
    ov_count = 0;
    x_init = WIDTH'(5); max_iter = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_out_valid", int'(out_valid), 0);
    check("zero_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("zero_done_after", int'(done), 0);
    check("zero_busy_after", int'(busy), 0);
    @(negedge clk);
    check("zero_pulses", ov_count, 0);
    check("zero_iter", int'(iter_count), 0);
    $display("zero limit run complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_state_update.md
# cnn_state_update

Sequential Euler-step state integrator for one CNN cell, directly upstream of the cell output stage. Holds the cell state X and, per accepted step, computes the increment dX = (−X + feedback + control + bias) >>> DT_SHIFT. Presents the pair (dX_out, Initial_X_out) to the output stage, which forms X + dX and applies the piecewise-linear output. Iterates until a step limit is reached or the state converges (dX = 0).

## Interface
- WIDTH, 9: signed data width of all state and operand ports.
- DT_SHIFT, 2: time-step exponent; dt = 2^−DT_SHIFT.
- ITER_W, 8: width of the iteration limit and iteration counter.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  loads x_init and max_iter; honoured only in IDLE.
- x_init  in  WIDTH  initial state; clamped to ±LIM on load.
- max_iter  in  ITER_W  step limit, sampled at start.
- fb_sum, ctrl_sum, bias  in  WIDTH each  signed feedback-template sum, control-template sum and bias for the current step.
- in_valid / in_ready  in / out  1  step-operand handshake.
- dX_out  out  WIDTH  registered clamped increment.
- Initial_X_out  out  WIDTH  registered state before the step.
- out_valid  out  1  one-cycle pulse marking dX_out/Initial_X_out valid.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on leaving RUN.
- converged  out  1  set when the run ended on dX = 0; held until the next start.
- iter_count  out  ITER_W  steps accepted in the current or last run.

## Operation
- LIM = 2^(WIDTH−2) − 1 (127 for WIDTH = 9). X and dX are both clamped to ±LIM. This keeps X + dX ± 1 within WIDTH, so the downstream absolute-value logic cannot overflow.
- Step sum is computed at WIDTH+2 bits, signed: s = −X + fb_sum + ctrl_sum + bias. dx = s >>> DT_SHIFT (arithmetic shift, floor toward −∞), then clamped to ±LIM.
- State update: X ← clamp(X + dx, ±LIM).
- States:
  - IDLE: in_ready = 0. On start, load X ← clamp(x_init), iter_count ← 0, converged ← 0. If max_iter = 0, go to DONE; otherwise go to RUN.
  - RUN: in_ready = 1. On in_valid, the step fires: register outputs, update X, iter_count++. If dx = 0, set converged and go to DONE. Otherwise, if iter_count+1 = max_iter, go to DONE. Otherwise stay in RUN. With in_valid low, nothing changes.
  - DONE: done = 1 for this single cycle, then go to IDLE.
- start is ignored in RUN and DONE.
- reset, including mid-run: state → IDLE; X, dX_out, Initial_X_out, iter_count = 0; out_valid, busy, done, converged, in_ready = 0.

## Timing
- Operand-to-output latency is 1 cycle. Operands accepted in cycle n appear on dX_out/Initial_X_out with out_valid = 1 in cycle n+1.
- The updated X is used by an operand accepted in cycle n+1, giving full throughput of 1 step per cycle.
- dX_out and Initial_X_out hold their values between steps. out_valid is high only in the cycle after a step fires.
- The final step's out_valid coincides with done. If that step converged, converged is also high in the same cycle.
- start→busy latency is 1 cycle. With max_iter = 0, done pulses 1 cycle after start and out_valid never asserts.
- No downstream backpressure exists; the output stage is combinational and always accepts.

## Structure
- Shared package holds WIDTH, DT_SHIFT, ITER_W, LIM, the state enum {IDLE, RUN, DONE} and the signed clamp function.
- One natural sub-module, cnn_step_alu: combinational sum, shift and clamp producing dx and X_next. The FSM, counter and output registers stay in the top module.

## Test plan
All scenarios use WIDTH = 9, DT_SHIFT = 2.
- Reset: assert reset for 2 cycles mid-RUN → all outputs 0 and in_ready = 0 in the following cycle; a new start works normally afterwards.
- Single step: x_init = 0, fb_sum = 40, others 0, max_iter = 1 → next cycle dX_out = 10, Initial_X_out = 0, out_valid = 1, done = 1, converged = 0, iter_count = 1.
- Convergence: x_init = 20, fb_sum = 20, others 0, max_iter = 5 → dX_out = 0, converged = 1, done after 1 step, iter_count = 1.
- Saturation: x_init = 100, fb_sum = ctrl_sum = bias = 255:
  - step 1: s = 665, shift gives 166, dX_out = 127, X → 127.
  - step 2: Initial_X_out = 127.
  - x_init = 300 is not representable, so instead check x_init = −256 → loads −127.
- Negative floor and gaps: x_init = 0, fb_sum = −5, max_iter = 3, in_valid toggled 1/0/1/0/1 → dX_out = −2 on the first step; exactly 3 out_valid pulses, each 1 cycle after an accepted operand; start pulses during RUN ignored.
- max_iter = 0 → done 1 cycle after start, no out_valid; busy never asserts.
